nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//   Multi-cycle adder for WIDTH-bit operands, one 4-bit slice (A+B+Cin) per cycle.
//   The carry is registered between slices, least-significant nibble first.
//   Sits in front of the 4-bit ripple datapath: it sequences wide operands into it
//   and collects its sum/carry. Valid/ready handshakes on both sides.
// PARAMETERS
//   WIDTH   16   operand/sum width in bits; multiple of 4, >= 8
//   N       (derived, WIDTH/4) nibble count; internal localparam, not overridable
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands a/b/cin valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in to nibble 0
//   out_valid  out  1      sum/cout/ovf valid (DONE only)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  A+B+cin, low WIDTH bits
//   cout       out  1      carry out of bit WIDTH-1
//   ovf        out  1      signed overflow: a[MSB]==b[MSB] && sum[MSB]!=a[MSB]
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0,
//     nibble index=0, carry reg=0. Reset wins over every other event in the same cycle.
//   FSM states IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready at edge T: latch a, b, cin into operand
//     regs; idx<=0; carry<=cin; sum<=0; -> RUN. Changes on a/b after T are ignored.
//   RUN: in_ready=0. Each cycle: {c4,s4} = a_r[4i+:4] + b_r[4i+:4] + carry;
//     sum[4i+:4]<=s4; carry<=c4; idx<=idx+1. On the cycle where idx==N-1, go to DONE.
//     In that same cycle, cout<=c4 and ovf is computed from the final sum MSB.
//   DONE: out_valid=1; sum/cout/ovf held stable until out_valid&&out_ready, then
//     -> IDLE (in_ready=1 on the next cycle). No new accept in the DONE->IDLE cycle.
//   Latency: accept at edge T; RUN spans cycles T+1..T+N; out_valid high from T+N+1.
//   Throughput: at most one op per N+2 cycles (no backpressure).
//   Width rules: the adder is unsigned modular. cout = bit WIDTH of the full sum.
//     ovf uses the two's-complement rule above and is independent of cout.
//   Backpressure: out_ready low in DONE holds all outputs with no state change. The
//     in_valid input is ignored while busy.
//   Reset mid-RUN or mid-DONE: operation is discarded. All outputs return to
//     reset values on the next cycle. No result is emitted.
//   out_ready high outside DONE: no effect.
//   sum bits are only meaningful while out_valid=1. Partial nibbles may be visible
//     during RUN.
// TESTING (WIDTH=16, N=4)
//   a=0x1234 b=0x4321 cin=0, accept at T -> out_valid at T+5: sum=0x5555 cout=0 ovf=0
//   a=0xFFFF b=0x0001 cin=0 -> sum=0x0000 cout=1 ovf=0 (carry ripples all 4 nibbles)
//   a=0x7FFF b=0x0001 cin=0 -> sum=0x8000 cout=0 ovf=1
//   a=0x0F0F b=0x00F0 cin=1 -> sum=0x1000 cout=0 ovf=0
//   Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, busy=1.
//     Raising out_ready, then in_ready=1 on the following cycle.
//   Assert rst at T+2 mid-RUN -> next cycle in_ready=1, out_valid=0, sum=0.
//     A following op a=0x0001 b=0x0001 completes with sum=0x0002.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice per cycle, least-significant nibble
// first, carry registered between slices. Valid/ready handshakes on both sides.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [3:0]       nib_a, nib_b;
    logic [4:0]       slice;
    logic             last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    // Current nibble selection and the 4-bit slice add
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                nib_a = a_r[4*i +: 4];
                nib_b = b_r[4*i +: 4];
            end
        end
        slice = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
        last  = (idx == IW'(N - 1));
    end

    // Operand capture and slice accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        if (idx == IW'(i)) sum[4*i +: 4] <= slice[3:0];
                    end
                    carry <= slice[4];
                    if (last) begin
                        idx  <= '0;
                        cout <= slice[4];
                        // slice[3] is the final sum MSB produced this cycle
                        ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                (slice[3] != a_r[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16 (four nibbles).
module tb_nibble_serial_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int total = 0;
    int bad   = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present operands for one edge, then scramble the inputs; returns at the
    // falling edge after the accept edge.
    task automatic start_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                            input logic vc);
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~va; b = ~vb; cin = ~vc;
    endtask

    // Counts edges until out_valid rises, bounded at 20.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     in_ready, out_valid, busy);
        end
        total++;
        if (sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: sum=%h cout=%b ovf=%b required 0000 0 0",
                     sum, cout, ovf);
        end
    endtask

    task automatic test_vectors;
        logic [WIDTH-1:0] va [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0F0F, 16'h8000, 16'hFFFF};
        logic [WIDTH-1:0] vb [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h00F0, 16'h8000, 16'hFFFF};
        logic             vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [WIDTH-1:0] es [6] = '{16'h5555, 16'h0000, 16'h8000, 16'h1000, 16'h0000, 16'hFFFF};
        logic             ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic             eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int cyc;
        for (int i = 0; i < 6; i++) begin
            start_op(va[i], vb[i], vc[i]);
            wait_done(cyc);
            total++;
            if (cyc !== N) begin
                bad++;
                $display("FAIL latency[%0d]: edges=%0d required %0d", i, cyc, N);
            end
            total++;
            if (sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
                bad++;
                $display("FAIL result[%0d]: sum=%h cout=%b ovf=%b required %h %b %b",
                         i, sum, cout, ovf, es[i], ec[i], eo[i]);
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL release[%0d]: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                         i, out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        start_op(16'h1234, 16'h1111, 1'b0);
        wait_done(cyc);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                sum !== 16'h2345 || cout !== 1'b0 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d]: ov=%b ir=%b busy=%b sum=%h c=%b o=%b required 1 0 1 2345 0 0",
                         k, out_valid, in_ready, busy, sum, cout, ovf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain: in_ready=%b busy=%b out_valid=%b required 1 0 0",
                     in_ready, busy, out_valid);
        end
    endtask

    task automatic test_idle_out_ready;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_out_ready: in_ready=%b busy=%b out_valid=%b required 1 0 0",
                     in_ready, busy, out_valid);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        start_op(16'h1234, 16'h4321, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0000) begin
            bad++;
            $display("FAIL mid_run_reset: ir=%b ov=%b busy=%b sum=%h required 1 0 0 0000",
                     in_ready, out_valid, busy, sum);
        end
        start_op(16'h0001, 16'h0001, 1'b0);
        wait_done(cyc);
        total++;
        if (cyc !== N || sum !== 16'h0002 || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_op: edges=%0d sum=%h c=%b o=%b required %0d 0002 0 0",
                     cyc, sum, cout, ovf, N);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_done;
        int cyc;
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done(cyc);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000 || cout !== 1'b0) begin
            bad++;
            $display("FAIL mid_done_reset: ov=%b ir=%b sum=%h cout=%b required 0 1 0000 0",
                     out_valid, in_ready, sum, cout);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_idle_out_ready();
        test_reset_mid_run();
        test_reset_mid_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
